// File: rtl/rr_request_arbiter.sv
// Round-robin request arbiter: registered one-hot grant, bounded hold time,
// and one idle cycle between successive owners.
module rr_request_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               request,
    output logic [NUM_REQ-1:0]               grant,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic                             busy,
    output logic                             expired,
    output logic [$clog2(MAX_HOLD+1)-1:0]    hold_count
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [NUM_REQ-1:0] grant_n;
    logic [ID_W-1:0]    id_n;
    logic [ID_W-1:0]    last;
    logic [ID_W-1:0]    last_n;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    cand;
    logic               found;
    logic [CNT_W-1:0]   hold_n;
    logic               expired_n;
    int unsigned        idx;

    // Scan upward from the slot after the previous owner, wrapping once.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx  = (32'(last) + i) % NUM_REQ;
            cand = ID_W'(idx);
            if (!found && request[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        id_n      = grant_id;
        last_n    = last;
        hold_n    = hold_count;
        expired_n = 1'b0;
        case (state)
            GRANT: begin
                // Release wins over timeout when both happen on the same edge.
                if (!request[grant_id]) begin
                    state_n = GAP;
                    grant_n = '0;
                    hold_n  = '0;
                end else if (hold_count == CNT_W'(MAX_HOLD)) begin
                    state_n   = GAP;
                    grant_n   = '0;
                    hold_n    = '0;
                    expired_n = 1'b1;
                end else begin
                    hold_n = hold_count + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                hold_n  = '0;
                if (found) begin
                    state_n      = GRANT;
                    grant_n[win] = 1'b1;
                    id_n         = win;
                    last_n       = win;
                    hold_n       = CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            grant_id   <= '0;
            last       <= ID_W'(NUM_REQ - 1);
            hold_count <= '0;
            busy       <= 1'b0;
            expired    <= 1'b0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            grant_id   <= id_n;
            last       <= last_n;
            hold_count <= hold_n;
            busy       <= |grant_n;
            expired    <= expired_n;
        end
    end

endmodule

// File: doc/rr_request_arbiter.md
# rr_request_arbiter

Round-robin arbiter that shares the single request/grant resource pipeline among NUM_REQ testbench or design requesters. Each requester holds `request[i]` high for as long as it needs the resource. The arbiter issues a registered one-hot grant, enforces a maximum hold time, and inserts one idle cycle between successive owners. It sits between the requesters and the resource's request input, and its grant timing is what clocking-block drivers synchronise against.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- MAX_HOLD, 8, maximum consecutive cycles one grant may stay high (>= 2)
- clock  input  1  single clock, all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state immediately
- request  input  NUM_REQ  per-requester level request; held high while the resource is wanted
- grant  output  NUM_REQ  one-hot or zero, registered
- grant_id  output  $clog2(NUM_REQ)  index of current owner; holds the last owner when idle
- busy  output  1  OR of grant, registered
- expired  output  1  one-cycle pulse when a grant is revoked by timeout
- hold_count  output  $clog2(MAX_HOLD+1)  cycles the current grant has been high, 0 when idle

## Operation
- States are IDLE, GRANT, GAP.
- **Reset values:** grant=0, grant_id=0, busy=0, expired=0, hold_count=0, state=IDLE. The priority pointer last=NUM_REQ-1, so requester 0 has top priority first.
- **IDLE**
  - If any request bit is high, pick the first set bit scanning (last+1) mod NUM_REQ upward with wrap.
  - Then set grant[w]=1, grant_id=w, last=w, hold_count=1, and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**, evaluated each posedge:
  - If request[grant_id]=0: clear grant, hold_count=0, go to GAP. This is a release.
  - Else if hold_count==MAX_HOLD: clear grant, expired=1, hold_count=0, go to GAP. This is a timeout.
  - Else hold_count+=1.
  - Requests from other requesters are ignored while in GRANT.
- **GAP:** one cycle with all grants low. At the next posedge, arbitrate exactly as in IDLE and go to GRANT if any request is high, else go to IDLE.
- The pointer advances only on a new grant. A requester whose grant expired remains eligible, but only after all other active requesters have been served.
- expired is high for exactly one cycle, the first GAP cycle, and is cleared at the next posedge.
- **Simultaneous release and limit:** if release and hold_count==MAX_HOLD occur on the same edge, it counts as a release and expired stays 0.
- **Reset mid-grant:** grant, busy and expired drop asynchronously. The first grant after reset deasserts again starts from requester 0.
- grant never has more than one bit set. grant_id changes only when a new grant is issued.

## Timing
- All inputs are sampled at posedge. All outputs are registered and change only after posedge or asynchronously on reset.
- **Request to grant latency:** 1 edge. request is high before edge k, and grant is high in the cycle after edge k.
- **Release to grant low:** 1 edge. request drops before edge e, and grant is low after edge e.
- **Minimum owner-to-owner gap:** exactly 1 cycle with grant=0. The next grant rises after edge e+1.
- **Maximum grant width:** MAX_HOLD cycles. expired rises on the same edge at which grant falls.
- **Clocking-block drivers:** a request written through the clocking block in the @(cb) timestep reaches the arbiter at that same edge, so it is sampled at the following edge. A grant sampled through an input clocking block is seen by the driver one edge after it rises.

## Test plan
- **Reset then single request:** NUM_REQ=4, reset deasserted, request=0001 at edge 2. Required: grant=0001 after edge 2 and hold_count=1; drop request before edge 5 → grant=0 after edge 5; busy tracks grant.
- **Round-robin rotation:** request=1111 held with MAX_HOLD=8, each owner drops its request bit for one edge after 3 cycles. Required: owners in order 0,1,2,3,0, with exactly one zero-grant cycle between owners.
- **Timeout:** MAX_HOLD=4, request=0100 held for 20 cycles. Required: grant[2] high exactly 4 cycles, then expired=1 for one cycle with grant=0, then grant[2] again after the GAP edge, repeating every 5 cycles.
- **Simultaneous release at limit:** drop request on the edge where hold_count==MAX_HOLD. Required: expired stays 0 and the next state is GAP.
- **Reset mid-grant:** assert reset while grant=0010 and hold_count=3. Required: grant=0, busy=0, expired=0 immediately without waiting for an edge. After release with request=1010, requester 1 wins first (pointer restored), not requester 3.
- **Fairness under contention:** request=1001 held continuously with MAX_HOLD=2. Required: grant alternates 0001 / 1000, each 2 cycles wide with a 1-cycle gap and an expired pulse after each, and neither requester is starved.
